// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state type and forwarding-select encodings for the RVX10-P hazard logic
package hazard_pkg;

   typedef enum logic {RUN, WAIT} hz_state_t;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_MEM  = 2'b01;
   localparam logic [1:0] FWD_WB   = 2'b10;

endpackage

// File: rtl/hazard_perf_ctr.sv
// hazard_perf_ctr: generic W-bit enable counter, wraps modulo 2^W, cleared by async reset
module hazard_perf_ctr #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   assign cnt_d = en_i ? cnt_q + W'(1) : cnt_q;

   // count one per enabled cycle
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the 5-stage RVX10-P pipeline (load-use, taken branch,
// data-memory wait states) with a sticky memory-timeout flag. Define HAZARD_PERF_EN to build the
// stall/flush/wait performance counters; otherwise those ports are tied to 0.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       RdE,
   input  logic             RegWriteE,
   input  logic             ResultSrcE0,
   input  logic             PCSrcE,
   input  logic             MemReqM,
   input  logic             dmem_ready,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] wait_cnt
);

   localparam int              WC_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WC_W-1:0] TMO  = WC_W'(MEM_TIMEOUT);

   hz_state_t       state_q, state_d;
   logic [WC_W-1:0] wcnt_q, wcnt_d;
   logic            mem_timeout_q, mem_timeout_d;
   logic            memwait, lw_stall;

   assign memwait  = MemReqM & ~dmem_ready;
   assign lw_stall = ResultSrcE0 & RegWriteE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

   // a memory wait freezes the whole front of the pipe and masks branch/load-use until it clears
   assign StallF = memwait | lw_stall;
   assign StallD = memwait | lw_stall;
   assign StallE = memwait;
   assign StallM = memwait;
   assign FlushW = memwait;
   assign FlushD = ~memwait & PCSrcE;
   assign FlushE = ~memwait & (lw_stall | PCSrcE);

   assign state_d       = (state_q == RUN) ? (memwait ? WAIT : RUN) : (dmem_ready ? RUN : WAIT);
   assign wcnt_d        = (state_q == WAIT && !dmem_ready) ? ((wcnt_q == TMO) ? wcnt_q : wcnt_q + WC_W'(1)) : '0;
   assign mem_timeout_d = mem_timeout_q | (wcnt_d == TMO);

   // wait FSM, saturating wait counter and sticky timeout flag
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q       <= RUN;
         wcnt_q        <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wcnt_q        <= wcnt_d;
         mem_timeout_q <= mem_timeout_d;
      end

   assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_EN
   hazard_perf_ctr #(.W(CNT_W)) u_stall_ctr (.clk(clk), .reset_n(reset_n), .en_i(StallF),          .cnt_o(stall_cnt));
   hazard_perf_ctr #(.W(CNT_W)) u_flush_ctr (.clk(clk), .reset_n(reset_n), .en_i(FlushD),          .cnt_o(flush_cnt));
   hazard_perf_ctr #(.W(CNT_W)) u_wait_ctr  (.clk(clk), .reset_n(reset_n), .en_i(state_q == WAIT), .cnt_o(wait_cnt));
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
   assign wait_cnt  = '0;
`endif

endmodule
